regfile_dumper: RTL and testbench
=================================

REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset (rst == 0 resets).
REQ-003 The block SHALL have the port start_i, input, 1 bit: request a full register dump; sampled only in IDLE.
REQ-004 The block SHALL have the port readEnable_o, output, 1 bit: read-port enable toward the register file.
REQ-005 The block SHALL have the port readAddr_o, output, 5 bits: read-port address toward the register file.
REQ-006 The block SHALL have the port readData_i, input, 32 bits: combinational read data returned in the same cycle as readAddr_o.
REQ-007 The block SHALL have the port data_o, output, 8 bits: stream byte.
REQ-008 The block SHALL have the port valid_o, output, 1 bit: data_o is valid.
REQ-009 The block SHALL have the port ready_i, input, 1 bit: the sink accepts data_o when valid_o && ready_i at a rising edge.
REQ-010 The block SHALL have the port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have the port done_o, output, 1 bit: one-cycle pulse after the last byte of a dump is accepted.

Function
REQ-012 The block SHALL implement the states IDLE, READ, SEND and DONE, plus HDR when DUMP_HEADER_EN is defined.
REQ-013 In IDLE with start_i == 1 at a rising edge, the block SHALL clear the register index idx to 0 and byte count cnt to 0, then go to READ (HDR when DUMP_HEADER_EN is defined).
REQ-014 In IDLE with start_i == 0, the block SHALL stay in IDLE; start_i SHALL be ignored in all other states.
REQ-015 In READ, the block SHALL drive readEnable_o = 1 and readAddr_o = idx, and SHALL hold readEnable_o = 0 in every other state.
REQ-016 In READ, the block SHALL capture readData_i into a 32-bit shift register at the rising edge, then go to SEND; READ SHALL last exactly one cycle.
REQ-017 In SEND, the block SHALL drive valid_o = 1 and data_o = shift[31:24], so bytes go out MSB first.
REQ-018 While valid_o && !ready_i, the block SHALL hold data_o, valid_o and all state unchanged.
REQ-019 On each accepted SEND byte, the block SHALL shift the shift register left by 8 and increment cnt (2 bits, wraps 3 -> 0).
REQ-020 When the byte with cnt == 3 is accepted and idx != 31, the block SHALL increment idx, then go to READ (HDR when DUMP_HEADER_EN is defined).
REQ-021 When the byte with cnt == 3 is accepted and idx == 31, the block SHALL go to DONE.
REQ-022 In DONE, the block SHALL assert done_o = 1 for exactly one cycle, then go unconditionally to IDLE.
REQ-023 The block SHALL emit register 0 as whatever readData_i returns (0 from the register file); it SHALL NOT special-case register 0.
REQ-024 With a continuously ready sink and no header, latency SHALL be: start_i sampled at edge 0, readEnable_o high in cycle 1, first valid_o in cycle 2, 5 cycles per register, done_o in cycle 161.
REQ-025 When valid_o == 0, data_o SHALL be 8'h00.

Reset
REQ-026 While rst == 0, the block SHALL immediately force state to IDLE, with idx = 0, cnt = 0 and shift = 0.
REQ-027 While rst == 0, the block SHALL drive readEnable_o = 0, readAddr_o = 0, data_o = 0, valid_o = 0, busy_o = 0 and done_o = 0.
REQ-028 On reset mid-dump, the block SHALL abandon the dump without a done_o pulse; a new start_i after release SHALL restart from register 0.

Configuration
REQ-029 With macro DUMP_HEADER_EN defined, the block SHALL enter state HDR before each READ.
REQ-030 In HDR, the block SHALL drive valid_o = 1 and data_o = {3'b000, idx}, and on acceptance go to READ; a dump is then 160 bytes.
REQ-031 With DUMP_HEADER_EN undefined, state HDR SHALL NOT exist and a dump SHALL be exactly 128 bytes.

Verification
REQ-032 Verification SHALL cover: regfile model r[n] = 32'hA5000000 | n with r[0] = 0, ready_i = 1, one start pulse -> 128 bytes 00 00 00 00 A5 00 00 01 ... A5 00 00 1F, then one done_o pulse.
REQ-033 Verification SHALL cover: ready_i toggling pseudo-randomly -> identical byte sequence, and data_o stable throughout every valid_o && !ready_i stall.
REQ-034 Verification SHALL cover: start_i held high through the whole dump -> exactly one dump, and a second dump begins only after returning to IDLE.
REQ-035 Verification SHALL cover: rst pulled low asynchronously mid-clock after 50 accepted bytes -> all outputs 0 without waiting for a clock edge and no done_o; a following start yields a full dump from register 0.
REQ-036 Verification SHALL cover: DUMP_HEADER_EN defined -> 160 bytes; bytes 0, 5 and 155 are 8'h00, 8'h01 and 8'h1F, each followed by the 4 data bytes of that register.
REQ-037 Verification SHALL cover: readEnable_o is high only in READ cycles (exactly 32 per dump), with readAddr_o taking the values 0..31 in order.

Source files
------------

// File: rtl/regfile_dumper.sv
// -----------------------------------------------------------------------------
// regfile_dumper
//
// Reads all 32 registers of a 32x32 register file through a single
// combinational read port and streams them out as bytes over a valid/ready
// interface, most significant byte of each register first.  A done_o pulse
// follows the last accepted byte.
//
// Optional feature (compile-time macro DUMP_HEADER_EN):
//   when defined, each register is preceded by a header byte {3'b000, idx},
//   so a dump is 160 bytes instead of 128.
//
// Ports:
//   clk          - clock, all state changes on rising edge
//   rst          - asynchronous active-low reset
//   start_i      - request a full dump (sampled only while idle)
//   readEnable_o - register-file read enable (high only in READ)
//   readAddr_o   - register-file read address
//   readData_i   - register-file read data, valid in the same cycle
//   data_o       - stream byte (8'h00 whenever valid_o is low)
//   valid_o      - data_o is valid
//   ready_i      - sink accepts data_o when valid_o && ready_i at a rising edge
//   busy_o       - high in every state except IDLE
//   done_o       - one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module regfile_dumper (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        readEnable_o,
    output logic [4:0]  readAddr_o,
    input  logic [31:0] readData_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
`ifdef DUMP_HEADER_EN
        ,
        S_HDR
`endif
    } state_t;

    // State entered at the start of every register: the header byte when
    // enabled, otherwise the read cycle directly.
`ifdef DUMP_HEADER_EN
    localparam state_t S_FIRST = S_HDR;
`else
    localparam state_t S_FIRST = S_READ;
`endif

    state_t      state_q, state_d;
    logic [4:0]  idx_q,   idx_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] shift_q, shift_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Outputs are decoded purely from the registered state, so an
    // asynchronous reset drives them all to zero without waiting for a clock.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case statement can infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        readEnable_o = 1'b0;
        readAddr_o   = '0;
        data_o       = 8'h00;
        valid_o      = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_FIRST;
                end
            end

            S_READ: begin
                readEnable_o = 1'b1;
                readAddr_o   = idx_q;
                shift_d      = readData_i;
                state_d      = S_SEND;
            end

            S_SEND: begin
                valid_o = 1'b1;
                data_o  = shift_q[31:24];
                if (ready_i) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    cnt_d   = cnt_q + 2'd1;
                    // Last byte of the current register.
                    if (cnt_q == 2'd3) begin
                        if (idx_q == 5'd31) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_FIRST;
                        end
                    end
                end
            end

`ifdef DUMP_HEADER_EN
            S_HDR: begin
                valid_o = 1'b1;
                data_o  = {3'b000, idx_q};
                if (ready_i) begin
                    state_d = S_READ;
                end
            end
`endif

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// -----------------------------------------------------------------------------
// tb_regfile_dumper
//
// Directed sequence of dumps against a behavioural register-file model
// r[n] = 32'hA5000000 | n (r[0] = 0).  The expected byte stream is built
// from the stream rules (optional header byte, then 4 bytes MSB first per
// register); observed bytes are those accepted on valid_o && ready_i.
// Honours DUMP_HEADER_EN when the bench is compiled with it.
// -----------------------------------------------------------------------------
module tb_regfile_dumper;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        readEnable_o;
    logic [4:0]  readAddr_o;
    logic [31:0] readData_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;

    regfile_dumper dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .readEnable_o (readEnable_o),
        .readAddr_o   (readAddr_o),
        .readData_i   (readData_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DUMP_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    function automatic logic [31:0] reg_val(input int n);
        return (n == 0) ? 32'h0 : (32'hA500_0000 + n);
    endfunction

    // Combinational register file.
    always_comb readData_i = reg_val(int'(readAddr_o));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Per-dump observations.
    int  re_cnt;
    int  done_cnt;
    int  first_re_cycle;
    int  first_valid_cycle;
    int  done_cycle;
    bit  finished;
    bit  aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected();
        logic [31:0] v;
        exp_q.delete();
        for (int n = 0; n < 32; n++) begin
            if (HDR) exp_q.push_back(8'(n));
            v = reg_val(n);
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_re"},    {31'b0, readEnable_o}, 32'd0);
        check({tag, "_addr"},  {27'b0, readAddr_o},   32'd0);
        check({tag, "_data"},  {24'b0, data_o},       32'd0);
        check({tag, "_valid"}, {31'b0, valid_o},      32'd0);
        check({tag, "_busy"},  {31'b0, busy_o},       32'd0);
        check({tag, "_done"},  {31'b0, done_o},       32'd0);
    endtask

    // One dump.  Inputs change and outputs are sampled 1 time unit after the
    // rising edge; "cycle k" is the cycle following rising edge k, with
    // start_i sampled at edge 0.
    task automatic run_dump(input bit rand_ready, input bit hold_start,
                            input int abort_after, input bit chk_latency);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        re_cnt = 0; done_cnt = 0; finished = 0; aborted = 0;
        first_re_cycle = -1; first_valid_cycle = -1; done_cycle = -1;
        prev_stall = 0; prev_data = 8'h00;

        @(negedge clk);
        start_i = 1'b1;
        ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;

        for (int c = 1; c <= 4000 && !finished; c++) begin
            @(posedge clk);
            #1;
            if (abort_after > 0 && got_q.size() == abort_after) begin
                #2 rst = 1'b0;
                #1;
                check_outputs_zero("async_rst");
                aborted = 1;
                break;
            end
            if (!hold_start) start_i = 1'b0;

            if (prev_stall) begin
                check("stall_valid", {31'b0, valid_o}, 32'd1);
                check("stall_data",  {24'b0, data_o},  {24'b0, prev_data});
            end
            if (!valid_o) check("idle_data_zero", {24'b0, data_o}, 32'd0);

            if (readEnable_o) begin
                if (first_re_cycle < 0) first_re_cycle = c;
                check("read_addr", {27'b0, readAddr_o}, 32'(re_cnt));
                re_cnt++;
            end
            if (valid_o && first_valid_cycle < 0) first_valid_cycle = c;
            if (done_o) begin
                done_cnt++;
                done_cycle = c;
                finished = 1;
            end

            ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (valid_o && ready_i) got_q.push_back(data_o);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end

        if (aborted) begin
            // No done_o while held in reset.
            repeat (3) begin
                @(posedge clk);
                #1;
                check("rst_no_done", {31'b0, done_o}, 32'd0);
            end
            @(negedge clk);
            rst = 1'b1;
            return;
        end

        check("dump_finished", {31'b0, finished}, 32'd1);
        check("read_count", 32'(re_cnt), 32'd32);
        check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("byte[%0d]", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});

        if (chk_latency) begin
            check("lat_first_read",  32'(first_re_cycle),    HDR ? 32'd2 : 32'd1);
            check("lat_first_valid", 32'(first_valid_cycle), HDR ? 32'd1 : 32'd2);
            // One cycle per byte plus one READ cycle per register, after cycle 0.
            check("lat_done", 32'(done_cycle), 32'(1 + exp_q.size() + 32));
        end

        // done_o is a single-cycle pulse followed by IDLE.
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, done_o}, 32'd0);
        check("idle_after_done", {31'b0, busy_o}, 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        build_expected();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle with no start stays idle.
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", {31'b0, busy_o}, 32'd0);

        // Continuously ready sink, single start pulse, latency checks.
        run_dump(1'b0, 1'b0, 0, 1'b1);

`ifdef DUMP_HEADER_EN
        check("hdr_byte0",   {24'b0, got_q[0]},   32'h00);
        check("hdr_byte5",   {24'b0, got_q[5]},   32'h01);
        check("hdr_byte155", {24'b0, got_q[155]}, 32'h1F);
`endif

        // Pseudo-random backpressure, same byte sequence.
        run_dump(1'b1, 1'b0, 0, 1'b0);
        run_dump(1'b1, 1'b0, 0, 1'b0);

        // start_i held through the whole dump: one dump, next one starts
        // only after passing through IDLE.
        run_dump(1'b0, 1'b1, 0, 1'b0);
        @(posedge clk);
        #1;
        check("restart_re",   {31'b0, readEnable_o}, HDR ? 32'd0 : 32'd1);
        check("restart_busy", {31'b0, busy_o},       32'd1);
        start_i = 1'b0;
        #3 rst = 1'b0;
        #1;
        check_outputs_zero("rst_cleanup");
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset after 50 accepted bytes, then a full dump.
        run_dump(1'b1, 1'b0, 50, 1'b0);
        check("abort_bytes", 32'(got_q.size()), 32'd50);
        run_dump(1'b0, 1'b0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
